// File: rtl/bram_stim_gen_pkg.sv
// Shared types and LFSR helpers for the bram stimulus generator.
// Galois right-shift LFSR; taps selected by data width (16 or 32).
package bram_stim_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    VERIFY = 2'd2,
    RUN    = 2'd3
  } state_t;

  localparam logic [15:0] TAPS_16 = 16'hB400;
  localparam logic [31:0] TAPS_32 = 32'h80200003;

  function automatic logic [31:0] lfsr_next(input int width, input logic [31:0] value);
    logic [31:0] taps;
    taps = (width == 32) ? TAPS_32 : {16'h0000, TAPS_16};
    return value[0] ? ((value >> 1) ^ taps) : (value >> 1);
  endfunction

endpackage

// File: rtl/bram_stim_gen_if.sv
// Control and bram-facing port bundle; master = generator, slave = bram/controller side.
// Signal names match the bram port list so the slave side wires straight through.
interface bram_stim_gen_if #(
  parameter int A_WID = 11,
  parameter int D_WID = 16
);
  logic             start;
  logic             stop;
  logic [D_WID-1:0] seed;
  logic [7:0]       duty_on;
  logic [7:0]       duty_off;
  logic [A_WID-1:0] wraddr;
  logic [D_WID-1:0] din;
  logic             we;
  logic             porta_en;
  logic             portb_en;
  logic [A_WID-1:0] rdaddr;
  logic [D_WID-1:0] dout;
  logic             busy;
  logic             err;
  logic [15:0]      err_cnt;

  modport master (
    input  start, stop, seed, duty_on, duty_off, dout,
    output wraddr, din, we, porta_en, portb_en, rdaddr, busy, err, err_cnt
  );

  modport slave (
    output start, stop, seed, duty_on, duty_off, dout,
    input  wraddr, din, we, porta_en, portb_en, rdaddr, busy, err, err_cnt
  );
endinterface

// File: rtl/bram_stim_gen_lfsr.sv
// Seedable Galois LFSR with advance enable; value is registered, resets to 1.
// Load has priority over advance; no backpressure.
module bram_stim_lfsr #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_seed,
  input  logic         i_adv,
  output logic [W-1:0] o_val
);
  import bram_stim_pkg::*;

  logic [W-1:0] r_val;
  logic [W-1:0] w_next;

  assign w_next = W'(lfsr_next(W, 32'(r_val)));
  assign o_val  = r_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_val <= W'(1);
    else if (i_load) r_val <= i_seed;
    else if (i_adv)  r_val <= w_next;
  end
endmodule

// File: rtl/bram_stim_gen.sv
// bram stimulus generator: LFSR fill, optional readback check (BRAM_STIM_CHECK_EN), duty-cycled toggle loop.
// All bram-facing outputs are registered one cycle behind the state; stop drops enables on the next edge.
module bram_stim_gen #(
  parameter int A_WID  = 11,
  parameter int D_WID  = 16,
  parameter int RD_OFS = 1 << (A_WID - 1)
) (
  input logic              clk,
  input logic              rst,
  bram_stim_gen_if.master  bus
);
  import bram_stim_pkg::*;

  localparam int               CW       = A_WID + 1;
  localparam logic [A_WID-1:0] ADDR_MAX = '1;
  localparam logic [A_WID-1:0] OFS      = A_WID'(RD_OFS);

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [A_WID-1:0] r_wraddr, r_rdaddr, w_wr_next;
  logic [D_WID-1:0] r_din, w_seed_eff, w_wr_lfsr;
  logic             r_we, r_pa, r_pb;
  logic [7:0]       r_don, r_doff;
  logic [8:0]       r_bidx;
  logic             w_start_ok, w_fill_last, w_run_act, w_burst_end, w_run_entry;

  assign w_start_ok  = (r_state == IDLE) && bus.start && !bus.stop;
  assign w_seed_eff  = (bus.seed == '0) ? D_WID'(1) : bus.seed;
  assign w_fill_last = (r_cnt[A_WID-1:0] == ADDR_MAX);
  assign w_wr_next   = r_wraddr + A_WID'(1);
  // Burst index runs 0..duty_on+duty_off-1; a zero-length burst resamples every cycle.
  assign w_run_act   = (r_bidx < {1'b0, r_don});
  assign w_burst_end = ((r_bidx + 9'd1) >= ({1'b0, r_don} + {1'b0, r_doff}));
  assign w_run_entry = (w_state_nxt == RUN) && (r_state != RUN);

  bram_stim_lfsr #(.W(D_WID)) u_wr_lfsr (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_start_ok),
    .i_seed (w_seed_eff),
    .i_adv  ((r_state == FILL) && !bus.stop),
    .o_val  (w_wr_lfsr)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:   if (w_start_ok) w_state_nxt = FILL;
`ifdef BRAM_STIM_CHECK_EN
      FILL:   if (w_fill_last) w_state_nxt = VERIFY;
`else
      FILL:   if (w_fill_last) w_state_nxt = RUN;
`endif
      VERIFY: if (r_cnt[A_WID]) w_state_nxt = RUN;
      RUN:    w_state_nxt = RUN;
      default: w_state_nxt = IDLE;
    endcase
    if ((r_state != IDLE) && bus.stop) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_wraddr <= '0;
      r_rdaddr <= '0;
      r_din    <= '0;
      r_we     <= 1'b0;
      r_pa     <= 1'b0;
      r_pb     <= 1'b0;
      r_don    <= '0;
      r_doff   <= '0;
      r_bidx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_we    <= 1'b0;
      r_pa    <= 1'b0;
      r_pb    <= 1'b0;
      if (w_start_ok) begin
        r_cnt <= '0;
      end else if (!bus.stop) begin
        case (r_state)
          FILL: begin
            r_we     <= 1'b1;
            r_pa     <= 1'b1;
            r_wraddr <= r_cnt[A_WID-1:0];
            r_din    <= w_wr_lfsr;
            r_cnt    <= w_fill_last ? '0 : r_cnt + CW'(1);
          end
          VERIFY: begin
            // Final count value is the trailing compare-only cycle: no read issued.
            r_pb <= !r_cnt[A_WID];
            if (!r_cnt[A_WID]) r_rdaddr <= r_cnt[A_WID-1:0];
            r_cnt <= r_cnt + CW'(1);
          end
          RUN: begin
            if (w_run_act) begin
              r_we     <= 1'b1;
              r_pa     <= 1'b1;
              r_pb     <= 1'b1;
              r_wraddr <= w_wr_next;
              r_rdaddr <= w_wr_next + OFS;
              r_din    <= ~r_din;
            end
            r_bidx <= w_burst_end ? 9'd0 : r_bidx + 9'd1;
          end
          default: ;
        endcase
      end
      if (w_run_entry || ((r_state == RUN) && w_burst_end)) begin
        r_don  <= bus.duty_on;
        r_doff <= bus.duty_off;
      end
      if (w_run_entry) r_bidx <= '0;
    end
  end

  assign bus.wraddr   = r_wraddr;
  assign bus.rdaddr   = r_rdaddr;
  assign bus.din      = r_din;
  assign bus.we       = r_we;
  assign bus.porta_en = r_pa;
  assign bus.portb_en = r_pb;
  assign bus.busy     = (r_state != IDLE);

`ifdef BRAM_STIM_CHECK_EN
  logic [D_WID-1:0] w_exp_lfsr, r_exp, r_exp_d;
  logic             r_cvld, r_cvld_d, r_err, w_rd_issue, w_mis;
  logic [15:0]      r_err_cnt;

  assign w_rd_issue = (r_state == VERIFY) && !bus.stop && !r_cnt[A_WID];
  assign w_mis      = r_cvld_d && (bus.dout != r_exp_d);

  bram_stim_lfsr #(.W(D_WID)) u_exp_lfsr (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_start_ok),
    .i_seed (w_seed_eff),
    .i_adv  (w_rd_issue),
    .o_val  (w_exp_lfsr)
  );

  // Expected value rides with rdaddr, then one more stage for the bram's rdaddr register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_exp     <= '0;
      r_exp_d   <= '0;
      r_cvld    <= 1'b0;
      r_cvld_d  <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_cvld   <= w_rd_issue;
      r_cvld_d <= r_cvld;
      r_exp_d  <= r_exp;
      if (w_rd_issue) r_exp <= w_exp_lfsr;
      if (w_start_ok) begin
        r_err     <= 1'b0;
        r_err_cnt <= '0;
      end else if (w_mis) begin
        r_err <= 1'b1;
        if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
      end
    end
  end

  assign bus.err     = r_err;
  assign bus.err_cnt = r_err_cnt;
`else
  logic w_unused_dout;
  assign w_unused_dout = ^bus.dout;
  assign bus.err       = 1'b0;
  assign bus.err_cnt   = '0;
`endif
endmodule

// File: doc/bram_stim_gen.md
# bram_stim_gen

Single-clock stimulus generator that sits directly upstream of the `bram` power/noise block and drives its write and read ports. It fills the memory with an LFSR pattern, optionally reads it back and checks it, then runs a duty-cycled full-toggle write/read loop for switching-activity and supply-noise measurement. One instance drives one `bram`, with that `bram` built with ONE_CLK=1.

## Interface
Parameters:
- A_WID, 11, address width; must match the driven `bram`.
- D_WID, 16, data width; legal values are 16 and 32 only.
- RD_OFS, 1<<(A_WID-1), read address offset from the write address in RUN.

Ports:
- clk  in  1  single clock; also drives the `bram` rdclk.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse; accepted only in IDLE.
- stop  in  1  level; forces a return to IDLE.
- seed  in  D_WID  LFSR seed, sampled on an accepted start; 0 is replaced by 1.
- duty_on  in  8  active cycles per RUN burst.
- duty_off  in  8  idle cycles per RUN burst.
- wraddr  out  A_WID  write address.
- din  out  D_WID  write data.
- we  out  1  write enable.
- porta_en  out  1  write port enable.
- portb_en  out  1  read port enable.
- rdaddr  out  A_WID  read address.
- dout  in  D_WID  `bram` read data; valid 1 cycle after rdaddr is presented with portb_en=1.
- busy  out  1  high whenever state is not IDLE.
- err  out  1  sticky mismatch flag; cleared by an accepted start.
- err_cnt  out  16  mismatch count; saturates at 16'hFFFF.

## Operation
- Reset value of every output is 0. State resets to IDLE, and the LFSR resets to 1.
- States are IDLE, FILL, VERIFY and RUN.
- **IDLE**
  - On start: load the LFSR with seed (or 1 if seed is 0), clear err and err_cnt, clear the address counter, go to FILL.
- **FILL**
  - we=porta_en=1.
  - wraddr counts 0..2^A_WID-1, one per cycle; din=LFSR, and the LFSR advances every cycle.
  - After the last address, go to VERIFY, or to RUN when the checker is compiled out.
- **VERIFY**
  - we=0, portb_en=1.
  - rdaddr counts 0..max; the expected-value LFSR restarts from the sampled seed.
  - dout is compared against the expected value 1 cycle later.
  - The last compare occurs in the first RUN cycle; this compare is still counted.
- **RUN**, as repeating bursts:
  - On-phase, duty_on cycles: we=porta_en=portb_en=1; wraddr increments with wrap modulo 2^A_WID; din inverts all bits every write; rdaddr=wraddr+RD_OFS, with wrap.
  - Off-phase, duty_off cycles: all enables are 0; addresses and din hold.
  - duty_on=0 means permanently off. duty_off=0 means permanently on.
  - duty values are resampled at each burst boundary.
- The LFSR is Galois, shifting right. Taps are 16'hB400 for D_WID=16 and 32'h80200003 for D_WID=32.
- **stop:** from any non-IDLE state, the next state is IDLE. Enables drop to 0 on the following edge; wraddr, rdaddr and din hold their last values.
- **start and stop asserted together in IDLE:** start is ignored.
- **start outside IDLE:** ignored.
- **rst mid-operation:** immediate return to reset values. No partial-write protection.

## Timing
- Start to first write: start is sampled at edge N; state=FILL, wraddr=0 and we=1 are visible after edge N+1.
- FILL lasts exactly 2^A_WID cycles. VERIFY lasts 2^A_WID cycles plus one compare cycle.
- Compare pipeline: the expected value is registered alongside rdaddr and delayed 1 cycle, to match `bram` rdaddr_r latency.
- err and err_cnt update 1 cycle after the mismatching dout.
- Burst counters: the first RUN cycle is an on-cycle when duty_on>0.

## Configuration
- BRAM_STIM_CHECK_EN
  - **Defined:** VERIFY state and the compare pipeline are present.
  - **Undefined:** FILL goes directly to RUN; err and err_cnt are tied to 0; the dout port remains but is unused.

## Structure
- Package `bram_stim_pkg` holds:
  - state enum typedef (IDLE/FILL/VERIFY/RUN);
  - LFSR tap constants per width;
  - function `lfsr_next(width, value)`.
- One sub-module, `bram_stim_lfsr` (seedable, advance enable), is instantiated twice: once for the write generator and once for the expected-value generator.

## Test plan
- A_WID=4, seed=16'h0001, start, checker on → 16 writes with din=1,16'hB400,16'h5A00,…; then 16 reads; err=0, err_cnt=0; RUN entered 34 cycles after start.
- Same setup, force dout bit0 flipped on the 3rd VERIFY read → err=1 and err_cnt=1 one cycle later; err stays 1 through RUN until the next start.
- RUN with duty_on=3, duty_off=2 → we pattern 1,1,1,0,0 repeating; din alternates X,~X,X across writes; rdaddr−wraddr=8 (mod 16) throughout.
- RUN with wraddr=15 → next write wraddr=0, rdaddr=8; no glitch on we.
- Assert stop mid-FILL at wraddr=5 → all enables 0 the following cycle, busy=0; wraddr holds 5.
- Assert rst mid-RUN → all outputs 0 immediately; a new start with seed=0 uses seed 1.
